// File: rtl/mmio_uart_tx_if.sv
// ----------------------------------------------------------------------------
// mmio_uart_tx_if
// Word-addressed MMIO store/read bundle between the CPU core and the UART
// transmitter.
//   i_mmio_addr  30  word address from core
//   i_mmio_data  32  store data from core
//   i_mmio_mask   4  byte-lane enables
//   i_mmio_wren   1  store strobe, one cycle per store
//   o_mmio_data  32  read data back to core (combinational on address)
// master = core side, slave = UART side.
// ----------------------------------------------------------------------------
interface mmio_uart_tx_if;
   logic [29:0] i_mmio_addr;
   logic [31:0] i_mmio_data;
   logic [3:0]  i_mmio_mask;
   logic        i_mmio_wren;
   logic [31:0] o_mmio_data;

   modport master (
      output i_mmio_addr, i_mmio_data, i_mmio_mask, i_mmio_wren,
      input  o_mmio_data
   );

   modport slave (
      input  i_mmio_addr, i_mmio_data, i_mmio_mask, i_mmio_wren,
      output o_mmio_data
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// ----------------------------------------------------------------------------
// mmio_uart_tx
// MMIO-mapped UART transmitter. Bytes written to TXDATA are buffered in a
// FIFO and serialised LSB first on o_tx at a programmable baud divisor.
// Register map (word offsets from BASE_ADDR):
//   +0 TXDATA  (W)  mask[0] pushes data[7:0]; reads 0
//   +1 STATUS  (RW) [15:8] level, [4] parity mode (option), [3] overflow,
//                   [2] busy, [1] full, [0] empty; write data[3]=1 clears overflow
//   +2 DIVISOR (RW) [15:0], byte lanes per mask[1:0]
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   mmio      slave side of the MMIO bus bundle
//   o_tx      serial output, idle high
//   o_irq     high while the FIFO is empty and the transmitter is idle
// Optional feature: define MMIO_UART_TX_PARITY_EN for 8E1/8O1 frames.
// ----------------------------------------------------------------------------
module mmio_uart_tx #(
   parameter logic [29:0] BASE_ADDR  = 30'h0000_0400,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic            clk,
   input  logic            rst,
   mmio_uart_tx_if.slave   mmio,
   output logic            o_tx,
   output logic            o_irq
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef MMIO_UART_TX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [7:0]         fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [LVL_W-1:0]   level_reg;
   logic               overflow_reg;
   logic [15:0]        divisor_reg, div_lat_reg, cnt_reg;
   logic [7:0]         shift_reg;
   logic [2:0]         bit_idx_reg;
   logic               tx_reg, tx_next, irq_reg, busy;
`ifdef MMIO_UART_TX_PARITY_EN
   logic               parity_mode_reg, parity_bit_reg;
`endif

   // Address decode and write strobes
   logic sel_tx, sel_st, sel_div, push_req, push, pop, fifo_full, fifo_empty;
   logic baud_tick, st_wr, div_wr;
   assign sel_tx     = (mmio.i_mmio_addr == BASE_ADDR);
   assign sel_st     = (mmio.i_mmio_addr == BASE_ADDR + 30'd1);
   assign sel_div    = (mmio.i_mmio_addr == BASE_ADDR + 30'd2);
   assign st_wr      = mmio.i_mmio_wren && sel_st && mmio.i_mmio_mask[0];
   assign div_wr     = mmio.i_mmio_wren && sel_div;
   assign fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));
   assign fifo_empty = (level_reg == '0);
   assign push_req   = mmio.i_mmio_wren && sel_tx && mmio.i_mmio_mask[0];
   // Full is judged on the registered level, so a same-cycle pop never
   // makes room for a push.
   assign push       = push_req && !fifo_full;
   assign pop        = (state_reg == IDLE) && !fifo_empty;
   assign baud_tick  = (cnt_reg == div_lat_reg - 16'd1);

   logic unused_bits;
   assign unused_bits = ^{mmio.i_mmio_data[31:16], mmio.i_mmio_mask[3:2]};

   // FIFO storage: no reset so it maps onto plain RAM
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= mmio.i_mmio_data[7:0];
   end

   // State register and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
         divisor_reg  <= DIV_RESET;
         div_lat_reg  <= 16'd1;
         cnt_reg      <= '0;
         shift_reg    <= '0;
         bit_idx_reg  <= '0;
         tx_reg       <= 1'b1;
         irq_reg      <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
         parity_mode_reg <= 1'b0;
         parity_bit_reg  <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase

         if (push_req && fifo_full)
            overflow_reg <= 1'b1;
         else if (st_wr && mmio.i_mmio_data[3])
            overflow_reg <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
         if (st_wr) parity_mode_reg <= mmio.i_mmio_data[4];
`endif
         if (div_wr && mmio.i_mmio_mask[0]) divisor_reg[7:0]  <= mmio.i_mmio_data[7:0];
         if (div_wr && mmio.i_mmio_mask[1]) divisor_reg[15:8] <= mmio.i_mmio_data[15:8];

         // Frame start: the divisor is frozen here so mid-frame writes only
         // affect the next frame; 0 is promoted to 1 clk/bit.
         if (pop) begin
            shift_reg   <= fifo_mem[rd_ptr_reg];
            bit_idx_reg <= '0;
            div_lat_reg <= (divisor_reg == 16'd0) ? 16'd1 : divisor_reg;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_bit_reg <= (^fifo_mem[rd_ptr_reg]) ^ parity_mode_reg;
`endif
         end

         if (state_reg == IDLE || baud_tick)
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + 16'd1;

         if (state_reg == DATA && baud_tick) begin
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= bit_idx_reg + 3'd1;
         end

         tx_reg  <= tx_next;
         irq_reg <= fifo_empty && (state_reg == IDLE);
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (!fifo_empty) state_next = START;
         START: if (baud_tick) state_next = DATA;
         DATA:  if (baud_tick && bit_idx_reg == 3'd7)
`ifdef MMIO_UART_TX_PARITY_EN
                   state_next = PARITY;
         PARITY: if (baud_tick) state_next = STOP;
`else
                   state_next = STOP;
`endif
         STOP:  if (baud_tick) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic; the line level is registered so o_tx is glitch-free
   always_comb begin
      tx_next = 1'b1;
      busy    = (state_reg != IDLE);
      case (state_reg)
         START:  tx_next = 1'b0;
         DATA:   tx_next = shift_reg[0];
`ifdef MMIO_UART_TX_PARITY_EN
         PARITY: tx_next = parity_bit_reg;
`endif
         default: tx_next = 1'b1;
      endcase
   end

   // Register read mux, combinational on the address
   always_comb begin
      mmio.o_mmio_data = 32'h0;
      if (sel_st) begin
         mmio.o_mmio_data[15:8] = 8'(level_reg);
         mmio.o_mmio_data[3]    = overflow_reg;
         mmio.o_mmio_data[2]    = busy;
         mmio.o_mmio_data[1]    = fifo_full;
         mmio.o_mmio_data[0]    = fifo_empty;
`ifdef MMIO_UART_TX_PARITY_EN
         mmio.o_mmio_data[4]    = parity_mode_reg;
`endif
      end else if (sel_div) begin
         mmio.o_mmio_data[15:0] = divisor_reg;
      end
   end

   assign o_tx  = tx_reg;
   assign o_irq = irq_reg;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_mmio_uart_tx
// Directed self-checking bench for mmio_uart_tx: register reset values, lane
// writes, frame timing and bit order, FIFO overflow, divisor latching, reset
// mid-frame and (when MMIO_UART_TX_PARITY_EN is defined) the parity bit.
// ----------------------------------------------------------------------------
module tb_mmio_uart_tx;
   localparam logic [29:0] BASE = 30'h0000_0400;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic o_tx, o_irq;
   int   n_checks = 0;
   int   n_fail   = 0;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(16), .DIV_RESET(16'd434)) dut (
      .clk   (clk),
      .rst   (rst),
      .mmio  (bus),
      .o_tx  (o_tx),
      .o_irq (o_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end else begin
         $display("ok   %s observed=%h", tag, obs);
      end
   endtask

   // One store: drive, take the posedge, then park the bus on STATUS.
   task automatic store(input logic [29:0] off, input logic [31:0] d, input logic [3:0] m);
      bus.i_mmio_addr = BASE + off;
      bus.i_mmio_data = d;
      bus.i_mmio_mask = m;
      bus.i_mmio_wren = 1'b1;
      @(posedge clk);
      #1;
      bus.i_mmio_wren = 1'b0;
      bus.i_mmio_mask = 4'h0;
      bus.i_mmio_addr = BASE + 30'd1;
   endtask

   task automatic rd(input logic [29:0] off, output logic [31:0] d);
      bus.i_mmio_addr = BASE + off;
      #1;
      d = bus.o_mmio_data;
      bus.i_mmio_addr = BASE + 30'd1;
      #1;
   endtask

   // Waits (bounded) for a start bit, then compares every clk of the frame.
   // gap = number of high samples seen before the start bit.
   task automatic check_frame(input string tag, input logic [7:0] b, input int div,
                              input int nbits, input logic par, input bit chk_busy,
                              output int gap);
      logic [10:0] exp_bits;
      int errs, busy_errs;
      bit found;
      exp_bits = {1'b1, 1'b1, 8'h00, 1'b0};
      exp_bits[8:1] = b;
      if (nbits == 11) exp_bits[9] = par;
      gap = 0;
      found = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (o_tx == 1'b0) begin
            found = 1'b1;
            break;
         end
         gap++;
      end
      if (!found) begin
         check({tag, "_start_timeout"}, 32'd0, 32'd1);
         return;
      end
      if (chk_busy) check({tag, "_irq_low"}, 32'(o_irq), 32'd0);
      errs = 0;
      busy_errs = 0;
      for (int i = 0; i < nbits * div; i++) begin
         if (i > 0) @(negedge clk);
         if (o_tx !== exp_bits[i / div]) errs++;
         if (chk_busy && i < nbits * div - 1 && bus.o_mmio_data[2] !== 1'b1) busy_errs++;
      end
      check({tag, "_bit_errs"}, 32'(errs), 32'd0);
      if (chk_busy) check({tag, "_busy_errs"}, 32'(busy_errs), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int g, lows;
      bit found;
      bus.i_mmio_addr = BASE + 30'd1;
      bus.i_mmio_data = '0;
      bus.i_mmio_mask = '0;
      bus.i_mmio_wren = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state and register map
      rd(30'd1, d); check("reset_status", d, 32'h0000_0001);
      rd(30'd2, d); check("reset_divisor", d, 32'h0000_01B2);
      rd(30'd0, d); check("txdata_reads_0", d, 32'h0);
      check("reset_tx", 32'(o_tx), 32'd1);
      check("reset_irq", 32'(o_irq), 32'd1);
      store(30'd6, 32'h0000_FFFF, 4'b0011);
      rd(30'd2, d); check("out_of_window_store", d, 32'h0000_01B2);
      rd(30'd6, d); check("out_of_window_read", d, 32'h0);
      store(30'd2, 32'h0000_12FF, 4'b0001);
      rd(30'd2, d); check("div_low_lane_only", d, 32'h0000_01FF);
      store(30'd2, 32'h0000_0000, 4'b0000);
      rd(30'd2, d); check("div_no_lanes", d, 32'h0000_01FF);

      // Single frame, 4 clk/bit: 0,1,0,1,0,0,1,0,1,1
      store(30'd2, 32'd4, 4'b0011);
      store(30'd0, 32'h0000_00A5, 4'b0001);
      check_frame("a5", 8'hA5, 4, 10, 1'b0, 1'b1, g);
      check("a5_latency_gap", 32'(g), 32'd2);
      @(negedge clk); @(negedge clk);
      check("a5_irq_after", 32'(o_irq), 32'd1);
      rd(30'd1, d); check("a5_status_after", d, 32'h0000_0001);

      // Burst of 18 consecutive pushes at 2 clk/bit. Byte 0 leaves for the
      // shifter one cycle after its push, so pushes 1..16 fill all 16
      // entries and the 18th (8'h11) is dropped; 17 frames 00..10 follow.
      store(30'd2, 32'd2, 4'b0011);
      @(negedge clk);
      fork
         begin
            for (int k = 0; k < 18; k++) store(30'd0, 32'(k), 4'b0001);
            rd(30'd1, d); check("burst_status_peak", d, 32'h0000_100E);
            store(30'd1, 32'h0000_0008, 4'b0001);
            rd(30'd1, d); check("burst_ovf_cleared", d, 32'h0000_1006);
         end
         begin
            for (int f = 0; f < 17; f++) begin
               int gf;
               check_frame($sformatf("burst%0d", f), 8'(f), 2, 10, 1'b0, 1'b0, gf);
               if (f > 0) check($sformatf("burst%0d_gap", f), 32'(gf), 32'd1);
            end
         end
      join
      lows = 0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (o_tx == 1'b0) lows++;
      end
      check("burst_no_extra_frame", 32'(lows), 32'd0);
      rd(30'd1, d); check("burst_status_end", d, 32'h0000_0001);

      // Divisor change mid-frame only affects the next frame
      store(30'd2, 32'd8, 4'b0011);
      store(30'd0, 32'h0000_003C, 4'b0001);
      fork
         check_frame("div8", 8'h3C, 8, 10, 1'b0, 1'b0, g);
         begin
            repeat (30) @(negedge clk);
            store(30'd2, 32'd2, 4'b0011);
         end
      join
      rd(30'd2, d); check("div_readback_2", d, 32'h0000_0002);
      store(30'd0, 32'h0000_005A, 4'b0001);
      check_frame("div2", 8'h5A, 2, 10, 1'b0, 1'b1, g);
      store(30'd2, 32'd0, 4'b0011);
      store(30'd0, 32'h0000_00C3, 4'b0001);
      check_frame("div0", 8'hC3, 1, 10, 1'b0, 1'b1, g);

      // Reset mid-frame abandons everything
      @(negedge clk);
      store(30'd2, 32'd4, 4'b0011);
      for (int k = 0; k < 3; k++) store(30'd0, 32'h0, 4'b0001);
      found = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (o_tx == 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      check("rst_frame_started", 32'(found), 32'd1);
      repeat (12) @(negedge clk);
      check("rst_pre_tx_low", 32'(o_tx), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_edge_tx", 32'(o_tx), 32'd1);
      check("rst_edge_irq", 32'(o_irq), 32'd1);
      rst = 1'b0;
      rd(30'd1, d); check("rst_status", d, 32'h0000_0001);
      rd(30'd2, d); check("rst_divisor", d, 32'h0000_01B2);
      lows = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (o_tx == 1'b0) lows++;
      end
      check("rst_no_frames", 32'(lows), 32'd0);

      // Parity mode bit
      store(30'd1, 32'h0000_0010, 4'b0001);
`ifdef MMIO_UART_TX_PARITY_EN
      rd(30'd1, d); check("parity_mode_set", d, 32'h0000_0011);
      store(30'd2, 32'd3, 4'b0011);
      store(30'd0, 32'h0000_0007, 4'b0001);
      check_frame("odd07", 8'h07, 3, 11, 1'b0, 1'b1, g);
`else
      rd(30'd1, d); check("parity_bit_ignored", d, 32'h0000_0001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
